// File: rtl/softex_lane_scheduler.sv
// softex_lane_scheduler
//   Dispatches a single input stream across NUM_LANES datapath lanes with
//   round-robin arbitration over ready lanes. It records the issuing lane of each
//   beat in an order FIFO, and merges the lane results back in issue order.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (shared with the lanes)
//   enable_i               gates new dispatches; draining is unaffected
//   in_valid_i/in_ready_o  input stream handshake, in_data_i / in_last_i
//   lane_valid_o           one-hot dispatch valid, lane_ready_i per-lane ready
//   lane_data_o            input beat broadcast to every lane
//   res_valid_i/res_ready_o per-lane result handshake, res_data_i packed by lane
//   out_valid_o/out_ready_i merged output handshake, out_data_o
//   busy_o, done_o, outstanding_o  status toward the controller
module softex_lane_scheduler #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ORDER_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            enable_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    input  logic                            in_last_i,
    output logic [NUM_LANES-1:0]            lane_valid_o,
    input  logic [NUM_LANES-1:0]            lane_ready_i,
    output logic [DATA_WIDTH-1:0]           lane_data_o,
    input  logic [NUM_LANES-1:0]            res_valid_i,
    output logic [NUM_LANES-1:0]            res_ready_o,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] res_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [$clog2(ORDER_DEPTH):0]    outstanding_o
);

    localparam int unsigned LW = $clog2(NUM_LANES);
    localparam int unsigned PW = $clog2(ORDER_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [LW-1:0] rr_ptr;
    logic [LW-1:0] order_lane [ORDER_DEPTH];
    logic          order_last [ORDER_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          done_q;

    logic [LW-1:0] cand;
    logic [LW-1:0] idx;
    logic          cand_found;
    logic          full;
    logic          non_empty;
    logic [LW-1:0] head;
    logic          push;
    logic          pop;

    // Cyclic search starting at rr_ptr; index arithmetic wraps in LW bits
    // because NUM_LANES is a power of two.
    always_comb begin
        cand_found = 1'b0;
        cand       = rr_ptr;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            idx = rr_ptr + LW'(i);
            if (!cand_found && lane_ready_i[idx]) begin
                cand_found = 1'b1;
                cand       = idx;
            end
        end
    end

    assign full      = (count == CW'(ORDER_DEPTH));
    assign non_empty = (count != '0);
    assign head      = order_lane[rd_ptr];

    assign in_ready_o   = enable_i & ~clear_i & ~full & (|lane_ready_i);
    assign lane_valid_o = (in_valid_i & enable_i & ~full & ~clear_i & cand_found)
                          ? (NUM_LANES'(1) << cand) : '0;
    assign lane_data_o  = in_data_i;
    assign push         = in_valid_i & in_ready_o;

    // Only the head lane's result is visible or acknowledged, which keeps
    // the output in issue order while later lanes hold their results.
    always_comb begin
        out_data_o = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (head == LW'(i)) begin
                out_data_o = res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_valid_o = non_empty & res_valid_i[head];
    assign res_ready_o = (non_empty & out_ready_i) ? (NUM_LANES'(1) << head) : '0;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < ORDER_DEPTH; i++) begin
                order_lane[i] <= '0;
                order_last[i] <= 1'b0;
            end
        end else if (clear_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= pop & order_last[rd_ptr];
            if (push) begin
                order_lane[wr_ptr] <= cand;
                order_last[wr_ptr] <= in_last_i;
                wr_ptr             <= wr_ptr + 1'b1;
                rr_ptr             <= cand + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign busy_o        = non_empty;
    assign done_o        = done_q;
    assign outstanding_o = count;

endmodule

// File: tb/tb_softex_lane_scheduler.sv
module tb_softex_lane_scheduler;

    localparam int NL = 4;
    localparam int DW = 128;
    localparam int OD = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n, clear, enable, in_valid, in_last, out_ready;
    logic [DW-1:0] in_data;
    logic [NL-1:0] lane_rdy, lane_valid, res_ready;
    logic [NL-1:0] res_valid = '0;
    logic [NL*DW-1:0] res_data = '0;
    logic [DW-1:0] lane_data, out_data;
    logic in_ready, out_valid, busy, done;
    logic [CW-1:0] outstanding;

    int n_vec, n_err, cyc, acc;
    int lat [NL];
    logic [DW-1:0] lq_d [NL][$];
    int            lq_t [NL][$];
    logic [DW-1:0] out_q [$];
    int            pop_cyc [$];
    int            done_cyc [$];
    logic [NL-1:0]    mon_v;
    logic [NL*DW-1:0] mon_d;

    always #5 clk = ~clk;

    softex_lane_scheduler #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ORDER_DEPTH(OD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .lane_valid_o(lane_valid), .lane_ready_i(lane_rdy), .lane_data_o(lane_data),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .done_o(done), .outstanding_o(outstanding)
    );

    // Lane models (fixed latency per lane, cleared with clear) and output logger.
    always @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NL; i++) begin
                lq_d[i].delete();
                lq_t[i].delete();
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    void'(lq_d[i].pop_front());
                    void'(lq_t[i].pop_front());
                end
                if (lane_valid[i] && lane_rdy[i]) begin
                    lq_d[i].push_back(lane_data);
                    lq_t[i].push_back(cyc + lat[i]);
                end
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                pop_cyc.push_back(cyc);
            end
        end
        if (rst_n && done) done_cyc.push_back(cyc);
        cyc = cyc + 1;
        mon_v = '0;
        mon_d = '0;
        for (int i = 0; i < NL; i++) begin
            if (lq_d[i].size() > 0 && lq_t[i][0] <= cyc) begin
                mon_v[i] = 1'b1;
                mon_d[i*DW +: DW] = lq_d[i][0];
            end
        end
        res_valid <= mon_v;
        res_data  <= mon_d;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", DW'(busy), 0);
    endtask

    task automatic clear_logs();
        out_q.delete();
        pop_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < NL; i++) lat[i] = l;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1; lane_rdy = '1;
        set_lat(2);
        repeat (2) @(negedge clk);
        #1;
        check("rst_lane_valid", DW'(lane_valid), 0);
        check("rst_res_ready", DW'(res_ready), 0);
        check("rst_out_valid", DW'(out_valid), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_outstanding", DW'(outstanding), 0);
        check("rst_done", DW'(done), 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: round-robin over all-ready lanes, in-order output, single done pulse
        clear_logs();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = DW'(32'hD0 + k); in_last = (k == 7);
            #1;
            check("t1_in_ready", DW'(in_ready), 1);
            check("t1_lane", DW'(lane_valid), DW'(1 << (k % 4)));
        end
        @(negedge clk) begin in_valid = 1'b0; in_last = 1'b0; end
        wait_idle(40);
        repeat (2) @(negedge clk);
        check("t1_count", DW'(out_q.size()), 8);
        for (int k = 0; k < 8 && k < out_q.size(); k++) check("t1_data", out_q[k], DW'(32'hD0 + k));
        check("t1_done_cnt", DW'(done_cyc.size()), 1);
        if (done_cyc.size() == 1 && pop_cyc.size() == 8)
            check("t1_done_time", DW'(done_cyc[0]), DW'(pop_cyc[7] + 1));

        // 2: skip busy lanes (rr_ptr=1 after one beat to lane 0)
        clear_logs();
        @(negedge clk);
        in_valid = 1'b1; in_data = DW'(32'hE0); #1;
        check("t2_lane_a", DW'(lane_valid), 4'b0001);
        @(negedge clk);
        lane_rdy = 4'b0000; in_data = DW'(32'hE1); #1;
        check("t2_noready_in", DW'(in_ready), 0);
        check("t2_noready_lane", DW'(lane_valid), 0);
        @(negedge clk);
        lane_rdy = 4'b1001; #1;
        check("t2_skip_lane", DW'(lane_valid), 4'b1000);
        @(negedge clk);
        lane_rdy = 4'b1111; in_data = DW'(32'hE2); #1;
        check("t2_wrap_lane", DW'(lane_valid), 4'b0001);
        @(negedge clk) in_valid = 1'b0;
        wait_idle(40);
        check("t2_count", DW'(out_q.size()), 3);
        for (int k = 0; k < 3 && k < out_q.size(); k++) check("t2_data", out_q[k], DW'(32'hE0 + k));

        // 3: reorder - slow lane 0 holds back fast lane 1 (rr_ptr=1 here)
        clear_logs();
        lat[0] = 6; lat[1] = 1;
        @(negedge clk);
        lane_rdy = 4'b0001; in_valid = 1'b1; in_data = DW'(32'hA); #1;
        check("t3_lane_a", DW'(lane_valid), 4'b0001);
        @(negedge clk);
        lane_rdy = 4'b0010; in_data = DW'(32'hB); #1;
        check("t3_lane_b", DW'(lane_valid), 4'b0010);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid = 1'b0; lane_rdy = 4'b1111; #1;
            check("t3_hold_b", DW'(res_ready), 4'b0001);
            check("t3_no_out", DW'(out_valid), 0);
        end
        wait_idle(40);
        check("t3_count", DW'(out_q.size()), 2);
        if (out_q.size() == 2) begin
            check("t3_first", out_q[0], DW'(32'hA));
            check("t3_second", out_q[1], DW'(32'hB));
        end

        // 4: fill the order FIFO, then overlap pop and push
        clear_logs();
        set_lat(1);
        out_ready = 1'b0; acc = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = DW'(32'hF0 + acc); in_last = 1'b0; #1;
            if (in_ready) acc++;
        end
        check("t4_accepted", DW'(acc), 8);
        @(negedge clk); #1;
        check("t4_full_outst", DW'(outstanding), 8);
        check("t4_full_ready", DW'(in_ready), 0);
        out_ready = 1'b1; #1;
        check("t4_full_ready_or", DW'(in_ready), 0);
        check("t4_out_valid", DW'(out_valid), 1);
        @(negedge clk); #1;
        check("t4_after_pop", DW'(outstanding), 7);
        check("t4_ready_again", DW'(in_ready), 1);
        @(negedge clk); #1;
        check("t4_pushpop", DW'(outstanding), 7);
        in_valid = 1'b0;
        wait_idle(40);
        check("t4_count", DW'(out_q.size()), 9);
        for (int k = 0; k < 9 && k < out_q.size(); k++) check("t4_data", out_q[k], DW'(32'hF0 + k));

        // 5: clear with three beats outstanding
        clear_logs();
        set_lat(2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = DW'(32'h50 + k); in_last = (k == 2);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; #1;
        check("t5_outst", DW'(outstanding), 3);
        in_valid = 1'b1; clear = 1'b1; #1;
        check("t5_clr_ready", DW'(in_ready), 0);
        check("t5_clr_lane", DW'(lane_valid), 0);
        @(negedge clk);
        clear = 1'b0; #1;
        check("t5_outst0", DW'(outstanding), 0);
        check("t5_busy0", DW'(busy), 0);
        check("t5_rr0", DW'(lane_valid), 4'b0001);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_out", DW'(out_q.size()), 0);
        check("t5_no_done", DW'(done_cyc.size()), 0);
        check("t5_out_valid", DW'(out_valid), 0);

        // 6: enable low stops dispatch, draining continues
        clear_logs();
        set_lat(1);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = DW'(32'hC0 + k);
        end
        @(negedge clk);
        enable = 1'b0; in_data = DW'(32'hC2); #1;
        check("t6_ready", DW'(in_ready), 0);
        check("t6_lane", DW'(lane_valid), 0);
        check("t6_outst", DW'(outstanding), 2);
        out_ready = 1'b1;
        wait_idle(20);
        check("t6_count", DW'(out_q.size()), 2);
        for (int k = 0; k < 2 && k < out_q.size(); k++) check("t6_data", out_q[k], DW'(32'hC0 + k));
        check("t6_lane_end", DW'(lane_valid), 0);
        in_valid = 1'b0; enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
